ifu_ras: RTL and testbench
==========================

Name: ifu_ras

Overview:
Next-generation instruction fetch unit with parametrised PC width and a return-address stack (RAS) for call/return jumps. It issues one fetch request at a time over a valid/target-valid handshake and advances the PC sequentially. It redirects on jumps; calls push a return address and returns pop one. It sits between the decode/branch logic (jump source) and the instruction memory port (fetch sink).

Parameters:
AW, 30, word-address width; the byte address is {PC, 2'b00}, AW+2 bits.
RST_PC, 0, word PC loaded at reset (AW bits).
RAS_DEPTH, 16, RAS entries; must be a power of 2, at least 2.
RAS_PW, 4, log2(RAS_DEPTH).

Ports:
i_Clk  in  1  clock, rising edge
i_RstN  in  1  asynchronous active-low reset
i_JmpV  in  1  jump valid, single-cycle pulse per jump
i_JmpC  in  2  jump command: 00 plain, 01 call (push), 10 return (pop), 11 treated as plain
i_JmpT  in  AW  jump target word PC; for return, used only as the underflow fallback
i_JmpSrc  in  AW  word PC of the jumping instruction; call pushes i_JmpSrc+1
o_FetchV  out  1  fetch request valid
o_FetchT  out  AW+2  fetch byte address {pc, 2'b00}
i_TrgtV  in  1  request accepted/served; the next request may be issued
o_RasCnt  out  RAS_PW+1  valid RAS entries, 0..RAS_DEPTH
o_RasOvf  out  1  one-cycle pulse: push into a full RAS overwrote the oldest entry
o_RasUnf  out  1  one-cycle pulse: pop from an empty RAS

Behaviour:
- One clock (i_Clk); reset is asynchronous and active-low (i_RstN).
- Reset values: pc=RST_PC, state BOOT, o_FetchV=0, o_FetchT={RST_PC,2'b00}, pend=0, RAS ptr=0, o_RasCnt=0, o_RasOvf=0, o_RasUnf=0. RAS array contents are not reset.
- Reset asserted mid-request drops the request immediately (o_FetchV=0 asynchronously). No response is expected afterwards.
- FSM BOOT: 1 cycle with o_FetchV=0, then REQ.
- FSM REQ: o_FetchV=1, o_FetchT={pc,2'b00}, held stable until i_TrgtV=1. At most one request is outstanding.
- On the i_TrgtV cycle the next pc is chosen in priority order:
  - (a) redirect target of a jump in the same cycle;
  - (b) else the pending target if pend=1;
  - (c) else pc+1, wrapping modulo 2^AW.
  - pend clears. The FSM stays in REQ and o_FetchV stays 1, so back-to-back requests give 1 request/cycle if i_TrgtV stays high.
- Jump without i_TrgtV: the in-flight request is not retracted. The redirect target goes into the pend register (pend=1). A later jump before acceptance overwrites it (last wins).
- Jump during BOOT: pc is loaded directly with the redirect target. The first request uses it.
- Redirect target: command 00/11 → i_JmpT; 01 → i_JmpT; 10 → RAS top if o_RasCnt>0, else i_JmpT.
- RAS update happens on the i_JmpV cycle, independent of i_TrgtV.
- Push (01): mem[ptr] <= i_JmpSrc+1 (mod 2^AW); ptr <= ptr+1 (mod RAS_DEPTH); cnt <= min(cnt+1, RAS_DEPTH). If cnt was RAS_DEPTH, the oldest entry is overwritten and o_RasOvf pulses.
- Pop (10): if cnt>0, target = mem[ptr-1], ptr <= ptr-1, cnt <= cnt-1. If cnt=0, target = i_JmpT, ptr/cnt unchanged, and o_RasUnf pulses.
- Pop after overflow returns the newest entries. After RAS_DEPTH pops the count is 0, even if more pushes occurred.
- i_TrgtV outside REQ is ignored. An i_JmpV pulse during the BOOT-cycle RAS update follows the same rules.

Test Plan:
1. Reset release, i_TrgtV held 1 → o_FetchV=0 for 1 cycle, then o_FetchT=0x0,0x4,0x8,0xC on consecutive cycles. With AW=4 and pc=0xF accepted, the next o_FetchT is 0x00 (wrap).
2. i_TrgtV low for 3 cycles with pc=5 → o_FetchT=0x14 stable, o_FetchV=1. Plain jump i_JmpT=0x40 in cycle 2, then i_TrgtV=1 → next o_FetchT=0x100. A second jump to 0x80 before acceptance → 0x200 instead.
3. Call i_JmpSrc=0x10, i_JmpT=0x100 concurrent with i_TrgtV → next o_FetchT=0x400, o_RasCnt=1. Later return (i_JmpT=0x3FF) → next o_FetchT=0x44, o_RasCnt=0.
4. Return with empty RAS, i_JmpT=0x20 → o_RasUnf pulses 1 cycle, next o_FetchT=0x80, o_RasCnt stays 0.
5. RAS_DEPTH=4: calls with src 1..5 → o_RasOvf pulses on the 5th call, o_RasCnt=4. Four returns yield targets 6,5,4,3; the fifth return underflows.
6. Assert i_RstN low while o_FetchV=1, pend=1, o_RasCnt=3 → o_FetchV=0 immediately, o_RasCnt=0. After release the first o_FetchT={RST_PC,2'b00}.

Source files
------------

// File: rtl/ifu_ras.sv
// Instruction fetch unit: sequential PC with single-outstanding fetch handshake,
// jump redirection and a circular return-address stack for call/return.
module ifu_ras #(
    parameter int unsigned    AW        = 30,
    parameter logic [AW-1:0]  RST_PC    = '0,
    parameter int unsigned    RAS_DEPTH = 16,
    parameter int unsigned    RAS_PW    = 4
) (
    input  logic              i_Clk,
    input  logic              i_RstN,
    input  logic              i_JmpV,
    input  logic [1:0]        i_JmpC,
    input  logic [AW-1:0]     i_JmpT,
    input  logic [AW-1:0]     i_JmpSrc,
    output logic              o_FetchV,
    output logic [AW+1:0]     o_FetchT,
    input  logic              i_TrgtV,
    output logic [RAS_PW:0]   o_RasCnt,
    output logic              o_RasOvf,
    output logic              o_RasUnf
);

    typedef enum logic {BOOT, REQ} state_t;

    localparam logic [RAS_PW:0] CNT_FULL = (RAS_PW+1)'(RAS_DEPTH);

    state_t              state, state_nxt;
    logic [AW-1:0]       pc;
    logic                pend;
    logic [AW-1:0]       pend_t;
    logic [AW-1:0]       ras_mem [RAS_DEPTH];
    logic [RAS_PW-1:0]   ptr;
    logic [RAS_PW-1:0]   ptr_m1;
    logic                is_call, is_ret, ras_hit;
    logic [AW-1:0]       redir_t;

    assign is_call = i_JmpV && (i_JmpC == 2'b01);
    assign is_ret  = i_JmpV && (i_JmpC == 2'b10);
    assign ptr_m1  = ptr - 1'b1;
    assign ras_hit = is_ret && (o_RasCnt != '0);
    assign redir_t = ras_hit ? ras_mem[ptr_m1] : i_JmpT;

    // Outputs decode straight from state so reset drops the request asynchronously.
    assign o_FetchV = (state == REQ);
    assign o_FetchT = {pc, 2'b00};

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) state <= BOOT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = REQ;
            REQ:     state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            pc     <= RST_PC;
            pend   <= 1'b0;
            pend_t <= '0;
        end else if (state == BOOT) begin
            if (i_JmpV) pc <= redir_t;
        end else if (i_TrgtV) begin
            if (i_JmpV)    pc <= redir_t;
            else if (pend) pc <= pend_t;
            else           pc <= pc + 1'b1;
            pend <= 1'b0;
        end else if (i_JmpV) begin
            pend   <= 1'b1;
            pend_t <= redir_t;
        end
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            ptr      <= '0;
            o_RasCnt <= '0;
            o_RasOvf <= 1'b0;
            o_RasUnf <= 1'b0;
        end else begin
            o_RasOvf <= 1'b0;
            o_RasUnf <= 1'b0;
            if (is_call) begin
                ptr <= ptr + 1'b1;
                if (o_RasCnt == CNT_FULL) o_RasOvf <= 1'b1;
                else                      o_RasCnt <= o_RasCnt + 1'b1;
            end else if (is_ret) begin
                if (ras_hit) begin
                    ptr      <= ptr_m1;
                    o_RasCnt <= o_RasCnt - 1'b1;
                end else begin
                    o_RasUnf <= 1'b1;
                end
            end
        end
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge i_Clk) begin
        if (is_call) ras_mem[ptr] <= i_JmpSrc + 1'b1;
    end

endmodule

// File: tb/tb_ifu_ras.sv
// Directed self-checking bench for ifu_ras (AW=12, RAS_DEPTH=4).
module tb_ifu_ras;

    localparam int unsigned AW = 12;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned RAS_PW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              jmp_v;
    logic [1:0]        jmp_c;
    logic [AW-1:0]     jmp_t;
    logic [AW-1:0]     jmp_src;
    logic              fetch_v;
    logic [AW+1:0]     fetch_t;
    logic              trgt_v;
    logic [RAS_PW:0]   ras_cnt;
    logic              ras_ovf;
    logic              ras_unf;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_ras #(
        .AW(AW),
        .RST_PC(12'h000),
        .RAS_DEPTH(RAS_DEPTH),
        .RAS_PW(RAS_PW)
    ) dut (
        .i_Clk(clk),
        .i_RstN(rst_n),
        .i_JmpV(jmp_v),
        .i_JmpC(jmp_c),
        .i_JmpT(jmp_t),
        .i_JmpSrc(jmp_src),
        .o_FetchV(fetch_v),
        .o_FetchT(fetch_t),
        .i_TrgtV(trgt_v),
        .o_RasCnt(ras_cnt),
        .o_RasOvf(ras_ovf),
        .o_RasUnf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [1:0] c, input logic [AW-1:0] t, input logic [AW-1:0] s);
        jmp_v = 1'b1; jmp_c = c; jmp_t = t; jmp_src = s;
    endtask

    initial begin
        rst_n = 1'b0; jmp_v = 1'b0; jmp_c = 2'b00; jmp_t = '0; jmp_src = '0; trgt_v = 1'b1;
        #12;
        chk("rst_fetch_v", 32'(fetch_v), 32'd0);
        chk("rst_fetch_t", 32'(fetch_t), 32'h0);
        chk("rst_cnt", 32'(ras_cnt), 32'd0);
        chk("rst_ovf", 32'(ras_ovf), 32'd0);
        chk("rst_unf", 32'(ras_unf), 32'd0);

        // Sequential fetch after reset release
        step(); rst_n = 1'b1;
        chk("boot_v", 32'(fetch_v), 32'd0);
        step(); chk("seq0_v", 32'(fetch_v), 32'd1); chk("seq0", 32'(fetch_t), 32'h0);
        step(); chk("seq1", 32'(fetch_t), 32'h4);
        step(); chk("seq2", 32'(fetch_t), 32'h8);
        step(); chk("seq3", 32'(fetch_t), 32'hC);

        // PC wraps modulo 2^AW
        jump(2'b00, 12'hFFF, 12'h0);
        step(); jmp_v = 1'b0; chk("wrap_top", 32'(fetch_t), 32'h3FFC);
        step(); chk("wrap", 32'(fetch_t), 32'h0);

        // Stalled request, pending jump
        jump(2'b00, 12'h005, 12'h0);
        step(); jmp_v = 1'b0; trgt_v = 1'b0; chk("pc5", 32'(fetch_t), 32'h14);
        step(); chk("stall1", 32'(fetch_t), 32'h14);
        jump(2'b00, 12'h040, 12'h0);
        step(); jmp_v = 1'b0; chk("stall2", 32'(fetch_t), 32'h14); chk("stall2_v", 32'(fetch_v), 32'd1);
        step(); chk("stall3", 32'(fetch_t), 32'h14);
        trgt_v = 1'b1;
        step(); chk("pend_tgt", 32'(fetch_t), 32'h100);
        trgt_v = 1'b0;
        jump(2'b00, 12'h040, 12'h0);
        step(); jump(2'b11, 12'h080, 12'h0);
        step(); jmp_v = 1'b0; trgt_v = 1'b1; chk("pend_hold", 32'(fetch_t), 32'h100);
        step(); chk("pend_last", 32'(fetch_t), 32'h200);
        step(); chk("after_pend", 32'(fetch_t), 32'h204);

        // Call then return
        jump(2'b01, 12'h100, 12'h010);
        step(); jmp_v = 1'b0; chk("call_t", 32'(fetch_t), 32'h400); chk("call_cnt", 32'(ras_cnt), 32'd1);
        step(); jump(2'b10, 12'h3FF, 12'h0);
        step(); jmp_v = 1'b0; chk("ret_t", 32'(fetch_t), 32'h44); chk("ret_cnt", 32'(ras_cnt), 32'd0);

        // Return on empty stack
        jump(2'b10, 12'h020, 12'h0);
        step(); jmp_v = 1'b0;
        chk("unf_t", 32'(fetch_t), 32'h80); chk("unf_p", 32'(ras_unf), 32'd1); chk("unf_cnt", 32'(ras_cnt), 32'd0);
        step(); chk("unf_clr", 32'(ras_unf), 32'd0);

        // Overflow with five calls, then drain
        for (int i = 1; i <= 5; i++) begin
            jump(2'b01, 12'h300, 12'(i));
            step();
            chk("ovf_p", 32'(ras_ovf), (i == 5) ? 32'd1 : 32'd0);
            chk("ovf_cnt", 32'(ras_cnt), (i >= 4) ? 32'd4 : 32'(i));
        end
        jmp_v = 1'b0;
        step(); chk("ovf_clr", 32'(ras_ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            jump(2'b10, 12'h7FF, 12'h0);
            step();
            chk("drain_t", 32'(fetch_t), 32'((6 - i) * 4));
            chk("drain_cnt", 32'(ras_cnt), 32'(3 - i));
        end
        jump(2'b10, 12'h7FF, 12'h0);
        step(); jmp_v = 1'b0;
        chk("drain_unf", 32'(ras_unf), 32'd1); chk("drain_unf_t", 32'(fetch_t), 32'h1FFC);

        // Reset during outstanding request with pending jump and filled stack
        for (int i = 0; i < 3; i++) begin
            jump(2'b01, 12'h050, 12'h020);
            step();
        end
        trgt_v = 1'b0; jump(2'b00, 12'h0AA, 12'h0);
        step(); jmp_v = 1'b0;
        chk("pre_rst_cnt", 32'(ras_cnt), 32'd3); chk("pre_rst_v", 32'(fetch_v), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 32'(fetch_v), 32'd0); chk("mid_rst_cnt", 32'(ras_cnt), 32'd0);
        chk("mid_rst_t", 32'(fetch_t), 32'h0);
        step(); rst_n = 1'b1; trgt_v = 1'b1;
        chk("rel_v", 32'(fetch_v), 32'd0);
        step(); chk("rel_t", 32'(fetch_t), 32'h0); chk("rel_v1", 32'(fetch_v), 32'd1);
        step(); chk("rel_next", 32'(fetch_t), 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
